// File: rtl/front_panel_ctrl.sv
// -----------------------------------------------------------------------------
// front_panel_ctrl
//
// Front-panel input controller for the rj32 board. It takes the raw front-panel
// buttons and drives the CPU's step/run_slow/run_fast/run_faster inputs.
//
// Each active-low button pin goes through a 2-flop synchroniser and then a
// debouncer. The debouncer produces a stable state plus one-cycle
// pressed/released pulses.
//
// Bits 0..2 of the button vector control a stopped/running state machine:
//   bit 0 = step, bit 1 = run/stop, bit 2 = mode.
// Any higher bits are only debounced.
//
// Parameters:
//   NUM_BUTTONS      number of buttons (>= 3)
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before a new level is
//                    accepted (>= 2)
//   REPEAT_CYCLES    step auto-repeat period while step is held in STOPPED;
//                    0 disables auto-repeat
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   buttons_n   raw button pins, active-low, asynchronous to clock
//   halt        CPU halt flag; forces a stop
//   debounced   stable button state, 1 = pressed
//   pressed     one-cycle pulse per button on debounced 0->1
//   released    one-cycle pulse per button on debounced 1->0
//   step        one-cycle CPU step pulse
//   run_slow    running in mode 0
//   run_fast    running in mode 1
//   run_faster  running in mode 2
//   mode        current speed mode, 0..2
//   running     state machine is in RUNNING
// -----------------------------------------------------------------------------
module front_panel_ctrl #(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_n,
  input  logic                   halt,
  output logic [NUM_BUTTONS-1:0] debounced,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] released,
  output logic                   step,
  output logic                   run_slow,
  output logic                   run_fast,
  output logic                   run_faster,
  output logic [1:0]             mode,
  output logic                   running
);

  // Button bit assignments used by the state machine.
  localparam int BTN_STEP = 0;
  localparam int BTN_RUN  = 1;
  localparam int BTN_MODE = 2;

  // Counter widths.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  localparam bit            RPT_ON   = (REPEAT_CYCLES > 0);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input path: synchroniser + debouncer
  // ---------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] sync_meta;    // first synchroniser stage
  logic [NUM_BUTTONS-1:0] sync_sample;  // second stage, the debouncer's input
  logic [CW-1:0]          db_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] stable_next;

  // A button flips on the edge where its counter has already counted
  // DEBOUNCE_CYCLES-1 disagreeing cycles and the sample still disagrees.
  // That makes DEBOUNCE_CYCLES consecutive disagreeing samples in total.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    stable_next = debounced;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if ((sync_sample[i] != debounced[i]) && (db_cnt[i] == DB_LAST)) begin
        stable_next[i] = ~debounced[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta   <= '0;
      sync_sample <= '0;
      debounced   <= '0;
      pressed     <= '0;
      released    <= '0;
      // NOTE: the counter array is cleared on reset like any other flop. A
      // press that is half-way through debouncing must not survive a reset.
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every flop
      // then samples the values from before the edge, which is what makes the
      // two synchroniser stages real separate stages.
      sync_meta   <= ~buttons_n;
      sync_sample <= sync_meta;
      debounced   <= stable_next;
      // The pulses are registered alongside debounced, so each one coincides
      // with the first cycle the new level is visible.
      pressed     <= stable_next & ~debounced;
      released    <= ~stable_next & debounced;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        // Clear when the sample agrees with the stable state (this is how a
        // glitch is discarded) and also on the edge that accepts a new level.
        if ((sync_sample[i] == debounced[i]) || (stable_next[i] != debounced[i])) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run/stop state machine, step generation, mode selection
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [1:0]    mode_next;
  logic          step_manual;
  logic          rpt_fire;
  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_next;

  always_comb begin
    state_next = state;
    unique case (state)
      ST_STOPPED: if (pressed[BTN_RUN] && !halt)        state_next = ST_RUNNING;
      ST_RUNNING: if (halt || pressed[BTN_RUN])         state_next = ST_STOPPED;
      default:                                          state_next = ST_STOPPED;
    endcase

    // Mode wraps 2 -> 0. Any out-of-range value falls back to 0 as well.
    mode_next = mode;
    if (pressed[BTN_MODE]) begin
      mode_next = (mode >= 2'd2) ? 2'd0 : mode + 2'd1;
    end

    // A run press in the same cycle wins over a step press.
    step_manual = (state == ST_STOPPED) && pressed[BTN_STEP] && !pressed[BTN_RUN];

    // Auto-repeat fires when the counter reaches the end of its period while
    // step is still held in STOPPED.
    //
    // The cycle of pressed[0] itself is excluded: that cycle restarts the
    // period, so the first repeat comes REPEAT_CYCLES cycles after the manual
    // step.
    rpt_fire = RPT_ON && (state == ST_STOPPED) && debounced[BTN_STEP]
               && !pressed[BTN_STEP] && !pressed[BTN_RUN] && (rpt_cnt == RPT_LAST);

    if (!RPT_ON || (state != ST_STOPPED) || (state_next != ST_STOPPED)
        || !debounced[BTN_STEP] || pressed[BTN_STEP] || rpt_fire) begin
      rpt_next = '0;
    end else begin
      rpt_next = rpt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_STOPPED;
      mode       <= 2'd0;
      rpt_cnt    <= '0;
      step       <= 1'b0;
      running    <= 1'b0;
      run_slow   <= 1'b0;
      run_fast   <= 1'b0;
      run_faster <= 1'b0;
    end else begin
      state      <= state_next;
      mode       <= mode_next;
      rpt_cnt    <= rpt_next;
      step       <= step_manual || rpt_fire;
      // The run outputs are decoded from next-state values. They change on the
      // same edge as running and mode, so at most one of them is ever high.
      running    <= (state_next == ST_RUNNING);
      run_slow   <= (state_next == ST_RUNNING) && (mode_next == 2'd0);
      run_fast   <= (state_next == ST_RUNNING) && (mode_next == 2'd1);
      run_faster <= (state_next == ST_RUNNING) && (mode_next == 2'd2);
    end
  end

endmodule

// File: tb/tb_front_panel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_front_panel_ctrl
//
// Directed bench for front_panel_ctrl. It uses two instances, both with
// DEBOUNCE_CYCLES=4:
//   dut    REPEAT_CYCLES=0
//   dut_r  REPEAT_CYCLES=8
//
// Inputs are driven and outputs are sampled on the falling clock edge.
// One tick() is one clock cycle, so the "6 cycles after the pin edge"
// debounce latency is six ticks after the pin is changed.
// -----------------------------------------------------------------------------
module tb_front_panel_ctrl;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       halt;
  logic [2:0] buttons_n;
  logic [2:0] rbuttons_n;

  logic [2:0] debounced, pressed, released;
  logic       step, run_slow, run_fast, run_faster, running;
  logic [1:0] mode;

  logic [2:0] r_debounced, r_pressed, r_released;
  logic       r_step, r_run_slow, r_run_fast, r_run_faster, r_running;
  logic [1:0] r_mode;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  front_panel_ctrl #(.NUM_BUTTONS(3), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(0)) dut (
    .clock(clock), .reset(reset), .buttons_n(buttons_n), .halt(halt),
    .debounced(debounced), .pressed(pressed), .released(released), .step(step),
    .run_slow(run_slow), .run_fast(run_fast), .run_faster(run_faster),
    .mode(mode), .running(running)
  );

  front_panel_ctrl #(.NUM_BUTTONS(3), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(8)) dut_r (
    .clock(clock), .reset(reset), .buttons_n(rbuttons_n), .halt(halt),
    .debounced(r_debounced), .pressed(r_pressed), .released(r_released), .step(r_step),
    .run_slow(r_run_slow), .run_fast(r_run_fast), .run_faster(r_run_faster),
    .mode(r_mode), .running(r_running)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Pull a pin low and wait until the debounced press is visible.
  task automatic press_pin(input int idx);
    buttons_n[idx] = 1'b0;
    repeat (DB + 2) tick();
  endtask

  // Release a pin and wait until the debounced release is visible.
  task automatic release_pin(input int idx);
    buttons_n[idx] = 1'b1;
    repeat (DB + 2) tick();
  endtask

  // Pack all the run-related outputs for one-shot comparisons:
  //   {running, run_slow, run_fast, run_faster, mode}
  function automatic logic [5:0] run_vec();
    return {running, run_slow, run_fast, run_faster, mode};
  endfunction

  initial begin
    logic seen;

    reset      = 1'b1;
    halt       = 1'b0;
    buttons_n  = '1;
    rbuttons_n = '1;
    repeat (3) tick();

    // Reset state.
    check("reset_outputs",
          {debounced, pressed, released, step, run_slow, run_fast, run_faster, mode, running},
          '0);
    reset = 1'b0;
    tick();
    check("idle_after_reset", {debounced, step, run_vec()}, '0);

    // 1: a 3-cycle glitch is rejected.
    seen = 1'b0;
    buttons_n[0] = 1'b0;
    repeat (3) begin
      tick();
      seen |= debounced[0] | pressed[0] | step;
    end
    buttons_n[0] = 1'b1;
    repeat (10) begin
      tick();
      seen |= debounced[0] | pressed[0] | step;
    end
    check("glitch_rejected", seen, 1'b0);

    // 2: full press, with exact latency and pulse widths.
    buttons_n[0] = 1'b0;
    repeat (DB + 1) tick();
    check("press_lat_minus1", debounced[0], 1'b0);
    tick();
    check("press_lat_deb", debounced[0], 1'b1);
    check("press_pulse", pressed, 3'b001);
    check("step_not_yet", step, 1'b0);
    tick();
    check("step_pulse", step, 1'b1);
    check("press_pulse_end", pressed[0], 1'b0);
    tick();
    check("step_one_cycle", step, 1'b0);
    buttons_n[0] = 1'b1;
    repeat (DB + 1) tick();
    check("rel_lat_minus1", {debounced[0], released[0]}, 2'b10);
    tick();
    check("rel_lat", {debounced[0], released[0]}, 2'b01);
    tick();
    check("rel_pulse_end", released[0], 1'b0);
    check("still_stopped", running, 1'b0);

    // 3: run, then cycle through the modes, then halt.
    press_pin(1);
    check("run_press_seen", {pressed[1], running}, 2'b10);
    tick();
    check("run_slow_on", run_vec(), 6'b1_100_00);
    release_pin(1);
    check("run_held", run_vec(), 6'b1_100_00);
    press_pin(2);
    check("mode_press_no_change", run_vec(), 6'b1_100_00);
    tick();
    check("mode1", run_vec(), 6'b1_010_01);
    release_pin(2);
    press_pin(2);
    tick();
    check("mode2", run_vec(), 6'b1_001_10);
    release_pin(2);
    press_pin(2);
    tick();
    check("mode_wrap", run_vec(), 6'b1_100_00);
    release_pin(2);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_stops", run_vec(), 6'b0_000_00);

    // 4: run + step together -> run wins; step ignored while running.
    buttons_n[1:0] = 2'b00;
    repeat (DB + 2) tick();
    check("both_pressed", pressed, 3'b011);
    tick();
    check("both_run_no_step", {running, step}, 2'b10);
    seen = 1'b0;
    buttons_n[1:0] = 2'b11;
    repeat (DB + 2) begin
      tick();
      seen |= step;
    end
    check("both_no_late_step", seen, 1'b0);
    press_pin(0);
    tick();
    check("step_in_running", {running, step}, 2'b10);
    release_pin(0);
    press_pin(1);
    tick();
    check("stop_press", running, 1'b0);
    release_pin(1);

    // 5: auto-repeat on dut_r. Pulses are expected at +1, +9, +17 and +25
    // cycles after pressed[0]. The pin is released at +24, so debounced[0]
    // falls at +30, before the +33 repeat would be due.
    rbuttons_n[0] = 1'b0;
    repeat (DB + 2) tick();
    check("rpt_pressed", r_pressed[0], 1'b1);
    for (int t = 1; t <= 40; t++) begin
      tick();
      check($sformatf("rpt_step_t%0d", t), r_step,
            (t == 1) || (t == 9) || (t == 17) || (t == 25));
      if (t == 24) rbuttons_n[0] = 1'b1;
    end
    check("rpt_released", r_debounced[0], 1'b0);

    // 6: reset mid-debounce while running in mode 2.
    press_pin(1);
    release_pin(1);
    press_pin(2);
    release_pin(2);
    press_pin(2);
    release_pin(2);
    check("pre_reset_mode2", run_vec(), 6'b1_001_10);
    buttons_n[0] = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    buttons_n[0] = 1'b1;
    tick();
    check("mid_reset_outputs",
          {debounced, pressed, released, step, run_slow, run_fast, run_faster, mode, running},
          '0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen |= debounced[0] | pressed[0] | step;
    end
    check("inflight_press_lost", seen, 1'b0);
    check("post_reset_run", run_vec(), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/front_panel_ctrl.md
Name: front_panel_ctrl

Overview:
- Parametrised front-panel input controller for the rj32 board.
- Replaces the per-button debouncer instances and the hard-tied run_fast/run_faster CPU inputs with a single block.
- Debounces NUM_BUTTONS active-low buttons and generates press/release pulses.
- Runs a stopped/running state machine with three selectable run speeds and a step button with optional auto-repeat; the CPU's halt forces a stop.
- Sits in the top level on clock (12 MHz domain), between the button pins and the cpu step/run_slow/run_fast/run_faster inputs.

Parameters:
- NUM_BUTTONS, 3, number of buttons; minimum 3. Bit 0 = step, bit 1 = run/stop, bit 2 = mode; higher bits are debounce-only.
- DEBOUNCE_CYCLES, 120000, consecutive cycles a synchronised input must differ from the stable state before it is accepted (10 ms at 12 MHz); minimum 2.
- REPEAT_CYCLES, 0, step auto-repeat period in cycles while step is held in STOPPED; 0 disables auto-repeat.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- buttons_n  input  NUM_BUTTONS  raw button pins, active-low, asynchronous.
- halt  input  1  CPU halt flag.
- debounced  output  NUM_BUTTONS  stable button state, 1 = pressed.
- pressed  output  NUM_BUTTONS  one-cycle pulse per button on debounced 0→1.
- released  output  NUM_BUTTONS  one-cycle pulse per button on debounced 1→0.
- step  output  1  one-cycle CPU step pulse.
- run_slow  output  1  running, mode 0.
- run_fast  output  1  running, mode 1.
- run_faster  output  1  running, mode 2.
- mode  output  2  current speed mode, 0..2.
- running  output  1  FSM in RUNNING.

Behaviour:
- Reset (synchronous; clears everything, including mid-debounce or mid-repeat):
  - all outputs 0; mode=0; FSM=STOPPED; repeat counter=0.
  - synchroniser flops, stable state and debounce counters = 0 (released).
- Per-button input path:
  - ~buttons_n feeds a 2-flop synchroniser; the 2nd flop is the sample.
  - Debounce counter width is clog2(DEBOUNCE_CYCLES).
  - sample==stable → counter cleared.
  - sample!=stable → counter increments; when counter==DEBOUNCE_CYCLES-1 on that edge, stable flips and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and produces no change.
  - Latency from pin edge to debounced change: DEBOUNCE_CYCLES+2 cycles.
- pressed/released:
  - registered, asserted in the same cycle debounced first shows the new value, for exactly 1 cycle.
  - Buttons are independent; simultaneous pulses on several bits are allowed.
- FSM, evaluated each cycle from pressed[] and halt:
  - STOPPED → RUNNING: pressed[1] && !halt.
  - RUNNING → STOPPED: halt, or pressed[1]. halt has priority; same-cycle pressed[1] is ignored.
  - step, registered (1 cycle after pressed[0]): asserted when FSM==STOPPED && pressed[0] && !pressed[1].
  - Run press beats step press in the same cycle: no step, FSM goes to RUNNING.
  - step is never asserted in RUNNING.
  - step is allowed while halt=1; the CPU decides what a step means.
- Auto-repeat (REPEAT_CYCLES>0):
  - In STOPPED with debounced[0]=1, the repeat counter runs; every REPEAT_CYCLES cycles after pressed[0] it emits an extra step pulse.
  - Counter clears on debounced[0]=0, on leaving STOPPED, or on pressed[0].
- Mode:
  - pressed[2] advances mode 0→1→2→0; values 0..2 only, never 3.
  - Changes take effect immediately, including while running.
- Run outputs:
  - run_slow = running && mode==0; run_fast = running && mode==1; run_faster = running && mode==2.
  - Registered; at most one is high at a time.
  - All three go low the cycle after STOPPED is entered.

Test Plan:
1. DEBOUNCE_CYCLES=4: pull buttons_n[0] low for 3 cycles, then high → debounced/pressed stay 0, step never asserted.
2. DEBOUNCE_CYCLES=4, FSM STOPPED: hold buttons_n[0] low → debounced[0] rises 6 cycles after the pin edge with pressed[0] for 1 cycle; step high exactly 1 cycle later. Release → released[0] pulse 6 cycles after the release edge.
3. Press run (bit 1) → running=1, run_slow=1. Press mode twice → run_fast then run_faster, 1 cycle after each pressed[2]. Third press → run_slow. Assert halt → running=0 and all run_* = 0 next cycle.
4. STOPPED: press run and step simultaneously → running=1, no step pulse. In RUNNING, press step → no step.
5. REPEAT_CYCLES=8, STOPPED: hold step for 30 cycles after pressed[0] → step pulses at +1, +9, +17, +25; after release, no further pulses.
6. Assert reset mid-debounce while running in mode 2 → next cycle all outputs 0, mode=0, and the in-flight press never appears on debounced.
